// File: rtl/packet_injector_pkg.sv
// Shared NoC definitions: flit type codes, FSM state encoding and the
// destination-id width helper used by injectors and router port decoders.
package packet_injector_pkg;

  localparam int unsigned FLIT_NONE = 0;
  localparam int unsigned FLIT_HEAD = 1;
  localparam int unsigned FLIT_BODY = 2;
  localparam int unsigned FLIT_TAIL = 3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_e;

  // Node-id width: clog2 of the node count, never narrower than one bit.
  function automatic int unsigned dest_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/packet_injector_flit_out_reg.sv
// Registered link output with valid/ready hold: data is only replaced when
// the link can advance, and valid only drops on a completed handshake.
module flit_out_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         adv_c
);

  assign adv_c = !valid || ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/packet_injector.sv
// Packet injector: turns a destination request plus payload words into one
// head/body/tail flit packet. Define PACKET_INJECTOR_STATS_EN for counters.
module packet_injector
  import packet_injector_pkg::*;
#(
  parameter int unsigned N             = 4,
  parameter int unsigned INDEX         = 1,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned TYPE_WIDTH    = 2,
  parameter int unsigned FlitPerPacket = 6,
  localparam int unsigned DEST_W       = dest_w(N),
  localparam int unsigned PW           = DATA_WIDTH - TYPE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [DEST_W-1:0]     pkt_dest,
  input  logic                  word_valid,
  output logic                  word_ready,
  input  logic [PW-1:0]         word_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  busy
`ifdef PACKET_INJECTOR_STATS_EN
  ,
  output logic [15:0]           pkt_sent,
  output logic [15:0]           stall_cycles
`endif
);

  localparam int unsigned CNT_W = $clog2(FlitPerPacket);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FlitPerPacket - 2);
  localparam logic [DEST_W-1:0] SRC_ID = DEST_W'(INDEX);
  localparam logic [TYPE_WIDTH-1:0] T_HEAD = TYPE_WIDTH'(FLIT_HEAD);
  localparam logic [TYPE_WIDTH-1:0] T_BODY = TYPE_WIDTH'(FLIT_BODY);
  localparam logic [TYPE_WIDTH-1:0] T_TAIL = TYPE_WIDTH'(FLIT_TAIL);

  generate
    if (PW < 2 * DEST_W) begin : g_bad_pw
      $error("packet_injector: payload too narrow for source and destination ids");
    end
    if (FlitPerPacket < 3) begin : g_bad_fpp
      $error("packet_injector: FlitPerPacket must be at least 3");
    end
  endgenerate

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    load;
  logic [DATA_WIDTH-1:0]   load_flit;
  logic                    adv;

  flit_out_reg #(.W(DATA_WIDTH)) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_flit),
    .ready     (ready_out),
    .data      (data_out),
    .valid     (valid_out),
    .adv_c     (adv)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Requests and words are only taken when the output register can advance.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    load_flit  = '0;
    pkt_ready  = 1'b0;
    word_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pkt_ready = adv && !rst;
        if (pkt_valid && pkt_ready) begin
          load      = 1'b1;
          load_flit = {T_HEAD, PW'({SRC_ID, pkt_dest})};
          state_d   = ST_PAYLOAD;
          cnt_d     = '0;
        end
      end
      ST_PAYLOAD: begin
        word_ready = adv;
        if (word_valid && word_ready) begin
          load  = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q < LAST_CNT) begin
            load_flit = {T_BODY, word_data};
          end else begin
            load_flit = {T_TAIL, word_data};
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE) || valid_out;

`ifdef PACKET_INJECTOR_STATS_EN
  logic [TYPE_WIDTH-1:0] out_type;
  assign out_type = data_out[DATA_WIDTH-1 -: TYPE_WIDTH];

  // Free-running wrap-around counters of delivered packets and stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_sent     <= 16'd0;
      stall_cycles <= 16'd0;
    end else begin
      if (valid_out && ready_out && (out_type == T_TAIL)) pkt_sent <= pkt_sent + 16'd1;
      if (valid_out && !ready_out) stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
